// File: rtl/ball_pkg.sv
// Shared types for the multi-ball engine: fixed-point position/speed and the per-slot record.
package ball_pkg;

    localparam int COORD_W = 11;
    localparam int SPD_W   = 16;
    localparam int POS_W   = 32;
    localparam int LVL_W   = 2;

    typedef logic signed [SPD_W-1:0] speed_t;
    typedef logic signed [POS_W-1:0] pos_t;

    typedef struct packed {
        logic             active;
        logic [LVL_W-1:0] level;
        pos_t             x;
        pos_t             y;
        speed_t           vx;
        speed_t           vy;
    } ball_slot_t;

    function automatic int size_of(input logic [LVL_W-1:0] lvl, input int min_size);
        return min_size << lvl;
    endfunction

endpackage

// File: rtl/ball_step.sv
// One-slot frame update (gravity, wall bounce, clamp); purely combinational.
// Inactive slots pass through unchanged.
module ball_step
    import ball_pkg::*;
#(
    parameter int FRAC_BITS = 6,
    parameter int G         = 1,
    parameter int FRAME_W   = 640,
    parameter int FRAME_H   = 480,
    parameter int MIN_SIZE  = 8
)(
    input  ball_slot_t slot_i,
    output ball_slot_t slot_o
);

    int   size;
    pos_t lim_x, lim_y, vx_w, vy_w, nx, ny;
    logic bounce_x, bounce_y;

    always_comb begin
        slot_o   = slot_i;
        size     = size_of(slot_i.level, MIN_SIZE);
        lim_x    = pos_t'((FRAME_W - 1 - size) << FRAC_BITS);
        lim_y    = pos_t'((FRAME_H - 1 - size) << FRAC_BITS);
        vx_w     = pos_t'(slot_i.vx);
        vy_w     = pos_t'(slot_i.vy);
        bounce_x = (slot_i.x <= 0 && slot_i.vx < 0) || (slot_i.x >= lim_x && slot_i.vx > 0);
        bounce_y = (slot_i.y <= 0 && slot_i.vy < 0) || (slot_i.y >= lim_y && slot_i.vy > 0);

        // Position advances with the speed held before this frame's bounce/gravity.
        nx = slot_i.x + vx_w;
        ny = slot_i.y + vy_w;
        if (nx < 0)          nx = '0;
        else if (nx > lim_x) nx = lim_x;
        if (ny < 0)          ny = '0;
        else if (ny > lim_y) ny = lim_y;

        if (slot_i.active) begin
            slot_o.x  = nx;
            slot_o.y  = ny;
            slot_o.vx = bounce_x ? -slot_i.vx : slot_i.vx;
            slot_o.vy = bounce_y ? -slot_i.vy : speed_t'(slot_i.vy + speed_t'(G));
        end
    end

endmodule

// File: rtl/ball_bank_move.sv
// Bank of NUM_BALLS balls swept once per frame (one slot per cycle), plus spawn/split handshakes.
// Outputs are registered copies of slot state (one cycle lag); handshakes stall during a sweep.
module ball_bank_move
    import ball_pkg::*;
#(
    parameter int NUM_BALLS = 4,
    parameter int FRAC_BITS = 6,
    parameter int G         = 1,
    parameter int FRAME_W   = 640,
    parameter int FRAME_H   = 480,
    parameter int MIN_SIZE  = 8,
    parameter int MAX_LEVEL = 2,
    parameter int SPLIT_VY  = -96
)(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          startOfFrame,
    input  logic                          spawn_valid,
    output logic                          spawn_ready,
    input  logic [10:0]                   spawn_x,
    input  logic [10:0]                   spawn_y,
    input  logic [15:0]                   spawn_vx,
    input  logic [15:0]                   spawn_vy,
    input  logic [1:0]                    spawn_level,
    input  logic                          split_valid,
    output logic                          split_ready,
    input  logic [3:0]                    split_idx,
    output logic [NUM_BALLS-1:0][10:0]    topLeftX,
    output logic [NUM_BALLS-1:0][10:0]    topLeftY,
    output logic [NUM_BALLS-1:0][15:0]    Xspeed,
    output logic [NUM_BALLS-1:0][15:0]    Yspeed,
    output logic [NUM_BALLS-1:0]          active,
    output logic [NUM_BALLS-1:0][1:0]     level,
    output logic                          busy,
    output logic                          overrun
);

    localparam int IDX_W = $clog2(NUM_BALLS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BALLS - 1);

    typedef enum logic {S_IDLE, S_SWEEP} state_e;

    state_e           state_q;
    logic [IDX_W-1:0] idx_q;
    logic             overrun_q;
    ball_slot_t       slots_q [NUM_BALLS];

    ball_slot_t       step_out, split_src, parent_d, child_d, spawn_d;
    logic             free_found, split_in_range;
    logic [IDX_W-1:0] free_idx, sidx;
    speed_t           abs_vx;
    logic [1:0]       spawn_lvl;

    ball_step #(
        .FRAC_BITS (FRAC_BITS),
        .G         (G),
        .FRAME_W   (FRAME_W),
        .FRAME_H   (FRAME_H),
        .MIN_SIZE  (MIN_SIZE)
    ) u_step (
        .slot_i (slots_q[idx_q]),
        .slot_o (step_out)
    );

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_BALLS - 1; i >= 0; i--) begin
            if (!slots_q[i].active) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        split_ready = !reset && state_q == S_IDLE && !startOfFrame;
        spawn_ready = split_ready && free_found && !split_valid;
    end

    always_comb begin
        sidx           = split_idx[IDX_W-1:0];
        split_in_range = {28'd0, split_idx} < 32'(NUM_BALLS);
        split_src      = slots_q[sidx];
        abs_vx         = (split_src.vx < 0) ? -split_src.vx : split_src.vx;

        parent_d       = split_src;
        parent_d.level = split_src.level - 2'd1;
        parent_d.vx    = -abs_vx;
        parent_d.vy    = speed_t'(SPLIT_VY);
        // A motionless parent still needs its child to separate sideways.
        child_d        = parent_d;
        child_d.vx     = (split_src.vx == 0) ? speed_t'(1 << FRAC_BITS) : abs_vx;

        spawn_lvl      = (32'(spawn_level) > MAX_LEVEL) ? 2'(MAX_LEVEL) : spawn_level;
        spawn_d.active = 1'b1;
        spawn_d.level  = spawn_lvl;
        spawn_d.x      = {{(POS_W - COORD_W - FRAC_BITS){1'b0}}, spawn_x, {FRAC_BITS{1'b0}}};
        spawn_d.y      = {{(POS_W - COORD_W - FRAC_BITS){1'b0}}, spawn_y, {FRAC_BITS{1'b0}}};
        spawn_d.vx     = spawn_vx;
        spawn_d.vy     = spawn_vy;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            overrun_q <= 1'b0;
            for (int i = 0; i < NUM_BALLS; i++) slots_q[i] <= '0;
            topLeftX  <= '0;
            topLeftY  <= '0;
            Xspeed    <= '0;
            Yspeed    <= '0;
            active    <= '0;
            level     <= '0;
        end else begin
            for (int i = 0; i < NUM_BALLS; i++) begin
                topLeftX[i] <= slots_q[i].x[FRAC_BITS +: COORD_W];
                topLeftY[i] <= slots_q[i].y[FRAC_BITS +: COORD_W];
                Xspeed[i]   <= slots_q[i].vx;
                Yspeed[i]   <= slots_q[i].vy;
                active[i]   <= slots_q[i].active;
                level[i]    <= slots_q[i].level;
            end

            case (state_q)
                S_IDLE: begin
                    if (startOfFrame) begin
                        state_q <= S_SWEEP;
                        idx_q   <= '0;
                    end else if (split_valid) begin
                        if (split_in_range && split_src.active) begin
                            if (split_src.level == 2'd0) begin
                                slots_q[sidx].active <= 1'b0;
                            end else begin
                                slots_q[sidx] <= parent_d;
                                if (free_found) slots_q[free_idx] <= child_d;
                            end
                        end
                    end else if (spawn_valid && spawn_ready) begin
                        slots_q[free_idx] <= spawn_d;
                    end
                end
                S_SWEEP: begin
                    slots_q[idx_q] <= step_out;
                    if (startOfFrame) overrun_q <= 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_q <= S_IDLE;
                        idx_q   <= '0;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy    = (state_q == S_SWEEP);
    assign overrun = overrun_q;

endmodule

// File: tb/tb_ball_bank_move.sv
// Directed bench for ball_bank_move: expectations are queued with each stimulus step and drained against outputs.
module tb_ball_bank_move;

    localparam int NB = 4;

    logic              clk = 1'b0;
    logic              reset, startOfFrame, spawn_valid, split_valid;
    logic              spawn_ready, split_ready, busy, overrun;
    logic [10:0]       spawn_x, spawn_y;
    logic [15:0]       spawn_vx, spawn_vy;
    logic [1:0]        spawn_level;
    logic [3:0]        split_idx;
    logic [NB-1:0][10:0] topLeftX, topLeftY;
    logic [NB-1:0][15:0] Xspeed, Yspeed;
    logic [NB-1:0]       active;
    logic [NB-1:0][1:0]  level;

    always #5 clk = ~clk;

    ball_bank_move dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
        .spawn_valid(spawn_valid), .spawn_ready(spawn_ready),
        .spawn_x(spawn_x), .spawn_y(spawn_y), .spawn_vx(spawn_vx), .spawn_vy(spawn_vy),
        .spawn_level(spawn_level),
        .split_valid(split_valid), .split_ready(split_ready), .split_idx(split_idx),
        .topLeftX(topLeftX), .topLeftY(topLeftY), .Xspeed(Xspeed), .Yspeed(Yspeed),
        .active(active), .level(level), .busy(busy), .overrun(overrun)
    );

    typedef enum int {O_X, O_Y, O_VX, O_VY, O_ACT, O_LVL, O_BUSY, O_OVR, O_SRDY, O_PRDY} obs_e;
    typedef struct {
        string       tag;
        obs_e        sel;
        int          slot;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] observe(obs_e sel, int slot);
        case (sel)
            O_X:    return {21'd0, topLeftX[slot]};
            O_Y:    return {21'd0, topLeftY[slot]};
            O_VX:   return {{16{Xspeed[slot][15]}}, Xspeed[slot]};
            O_VY:   return {{16{Yspeed[slot][15]}}, Yspeed[slot]};
            O_ACT:  return {28'd0, active};
            O_LVL:  return {30'd0, level[slot]};
            O_BUSY: return {31'd0, busy};
            O_OVR:  return {31'd0, overrun};
            O_SRDY: return {31'd0, spawn_ready};
            O_PRDY: return {31'd0, split_ready};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic want(string tag, obs_e sel, int slot, logic [31:0] val);
        exp_t e;
        e.tag  = tag;
        e.sel  = sel;
        e.slot = slot;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] got;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            got = observe(e.sel, e.slot);
            n_cmp++;
            assert (got === e.val) else begin
                n_bad++;
                $error("FAIL %s slot%0d observed=%0h expected=%0h", e.tag, e.slot, got, e.val);
            end
        end
    endtask

    task automatic chk(string tag, int got, int exp_v);
        n_cmp++;
        assert (got === exp_v) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp_v);
        end
    endtask

    task automatic do_spawn(int x, int y, int vx, int vy, int lvl);
        spawn_x     = 11'(x);
        spawn_y     = 11'(y);
        spawn_vx    = 16'(vx);
        spawn_vy    = 16'(vy);
        spawn_level = 2'(lvl);
        spawn_valid = 1'b1;
        #1;
        chk("spawn_ready", int'(spawn_ready), 1);
        tick();
        spawn_valid = 1'b0;
    endtask

    task automatic do_split(int idx);
        split_idx   = 4'(idx);
        split_valid = 1'b1;
        #1;
        chk("split_ready", int'(split_ready), 1);
        tick();
        split_valid = 1'b0;
    endtask

    task automatic do_frame();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        repeat (NB + 1) tick();
    endtask

    initial begin
        int n;
        reset = 1'b1; startOfFrame = 1'b0; spawn_valid = 1'b0; split_valid = 1'b0;
        spawn_x = '0; spawn_y = '0; spawn_vx = '0; spawn_vy = '0; spawn_level = '0; split_idx = '0;

        // Reset state, held with requests pending.
        tick(); tick();
        spawn_valid = 1'b1; split_valid = 1'b1; #1;
        want("rst_active", O_ACT, 0, 0);
        want("rst_busy", O_BUSY, 0, 0);
        want("rst_overrun", O_OVR, 0, 0);
        want("rst_spawn_rdy", O_SRDY, 0, 0);
        want("rst_split_rdy", O_PRDY, 0, 0);
        want("rst_x0", O_X, 0, 0);
        drain();
        spawn_valid = 1'b0; split_valid = 1'b0;
        reset = 1'b0;
        tick();

        // Basic spawn and one frame.
        do_spawn(100, 100, 64, 0, 0);
        tick();
        want("spawn_active", O_ACT, 0, 4'b0001);
        want("spawn_x", O_X, 0, 100);
        want("spawn_y", O_Y, 0, 100);
        drain();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            n++;
            tick();
        end
        chk("busy_cycles", n, NB);
        tick();
        want("f1_x", O_X, 0, 101);
        want("f1_y", O_Y, 0, 100);
        want("f1_vy", O_VY, 0, 1);
        want("f1_vx", O_VX, 0, 64);
        drain();

        // Left-wall bounce (slot 1) and floor bounce without gravity (slot 2).
        do_spawn(0, 200, -64, 0, 0);
        do_spawn(300, 471, 0, 32, 0);
        do_frame();
        want("wall_vx", O_VX, 1, 64);
        want("wall_x", O_X, 1, 0);
        want("wall_y", O_Y, 1, 200);
        want("floor_vy", O_VY, 2, 32'hFFFF_FFE0);
        want("floor_y", O_Y, 2, 471);
        want("f2_x0", O_X, 0, 102);
        want("f2_vy0", O_VY, 0, 2);
        drain();

        // Split a level-2 ball.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        do_spawn(200, 100, -40, 0, 2);
        do_split(0);
        tick();
        want("par_lvl", O_LVL, 0, 1);
        want("par_vx", O_VX, 0, 32'hFFFF_FFD8);
        want("par_vy", O_VY, 0, 32'hFFFF_FFA0);
        want("split_active", O_ACT, 0, 4'b0011);
        want("child_lvl", O_LVL, 1, 1);
        want("child_vx", O_VX, 1, 40);
        want("child_vy", O_VY, 1, 32'hFFFF_FFA0);
        want("child_x", O_X, 1, 200);
        want("child_y", O_Y, 1, 100);
        drain();

        // Saturated level, then fill the bank.
        do_spawn(10, 10, 0, 0, 3);
        tick();
        want("sat_level", O_LVL, 2, 2);
        drain();
        do_spawn(50, 50, 0, 0, 0);
        spawn_x = 11'd77; spawn_y = 11'd66; spawn_vx = '0; spawn_vy = '0; spawn_level = '0;
        spawn_valid = 1'b1;
        tick();
        want("full_spawn_rdy", O_SRDY, 0, 0);
        want("full_active", O_ACT, 0, 4'b1111);
        drain();
        split_idx = 4'd3; split_valid = 1'b1;
        #1;
        want("split_prio", O_SRDY, 0, 0);
        drain();
        tick();
        split_valid = 1'b0;
        #1;
        want("freed_spawn_rdy", O_SRDY, 0, 1);
        drain();
        tick();
        spawn_valid = 1'b0;
        want("pop_active", O_ACT, 0, 4'b0111);
        drain();
        tick();
        want("refill_active", O_ACT, 0, 4'b1111);
        want("refill_x", O_X, 3, 77);
        want("refill_y", O_Y, 3, 66);
        drain();

        // Out-of-range split index is accepted and ignored.
        do_split(9);
        tick();
        want("oor_active", O_ACT, 0, 4'b1111);
        drain();

        // Overrun, and split held off during a sweep.
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        tick();
        startOfFrame = 1'b1;
        split_idx = 4'd9; split_valid = 1'b1;
        #1;
        want("sweep_split_rdy", O_PRDY, 0, 0);
        drain();
        tick();
        startOfFrame = 1'b0;
        want("overrun", O_OVR, 0, 1);
        drain();
        n = 0;
        while (!split_ready && n < 20) begin
            tick();
            n++;
        end
        chk("split_wait", n, 2);
        split_valid = 1'b0;
        tick(); tick();
        want("no_resweep", O_BUSY, 0, 0);
        want("overrun_sticky", O_OVR, 0, 1);
        drain();

        // Reset in the middle of a sweep.
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        want("rst_mid_active", O_ACT, 0, 0);
        want("rst_mid_busy", O_BUSY, 0, 0);
        want("rst_mid_ovr", O_OVR, 0, 0);
        drain();
        chk("rst_mid_topleft", int'(topLeftX == '0 && topLeftY == '0), 1);
        reset = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
